// File: rtl/affine_param_pkg.sv
// affine_param_pkg: shared FSM state type and index-width helper for the affine parameter streamer
package affine_param_pkg;
   typedef enum logic {LOAD, STREAM} param_state_t;
   function automatic int idx_w(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction
endpackage

// File: rtl/affine_param_bank.sv
// affine_param_bank: DEPTH x LANES register file, sync write, async read, async active-low clear
module affine_param_bank
   import affine_param_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int DEPTH = 4,
   parameter int AW    = idx_w(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [LANES-1:0][WIDTH-1:0]  wdata,
   input  logic [AW-1:0]                raddr,
   output logic [LANES-1:0][WIDTH-1:0]  rdata
);
   logic [DEPTH-1:0][LANES-1:0][WIDTH-1:0] mem;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mem <= '0;
      else if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/affine_param_streamer.sv
// affine_param_streamer: holds one gamma/beta row and replays it endlessly on decoupled
// weight/bias valid/ready channels; reloads are taken only at a row boundary
module affine_param_streamer
   import affine_param_pkg::*;
#(
   parameter int IN_WIDTH   = 32,
   parameter int BIAS_WIDTH = 8,
   parameter int IN_SIZE    = 4,
   parameter int DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     load_weight,
   input  logic [IN_SIZE-1:0][BIAS_WIDTH-1:0]   load_bias,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic                                 reload_req,
   output logic [IN_SIZE-1:0][IN_WIDTH-1:0]     weight,
   output logic                                 weight_valid,
   input  logic                                 weight_ready,
   output logic [IN_SIZE-1:0][BIAS_WIDTH-1:0]   bias,
   output logic                                 bias_valid,
   input  logic                                 bias_ready,
   output logic                                 row_done,
   output logic                                 loaded
);
   localparam int AW = idx_w(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   param_state_t state, next_state;
   logic [AW-1:0] wr_idx, rd_idx;
   logic w_done, b_done, pending;
   logic load_fire, w_fire, b_fire, beat_done, row_end, go_load;
   logic [IN_SIZE-1:0][IN_WIDTH-1:0]   rd_weight;
   logic [IN_SIZE-1:0][BIAS_WIDTH-1:0] rd_bias;

   affine_param_bank #(.WIDTH(IN_WIDTH), .LANES(IN_SIZE), .DEPTH(DEPTH)) u_weight_bank (
      .clk(clk), .rst(rst), .we(load_fire), .waddr(wr_idx), .wdata(load_weight),
      .raddr(rd_idx), .rdata(rd_weight)
   );

   affine_param_bank #(.WIDTH(BIAS_WIDTH), .LANES(IN_SIZE), .DEPTH(DEPTH)) u_bias_bank (
      .clk(clk), .rst(rst), .we(load_fire), .waddr(wr_idx), .wdata(load_bias),
      .raddr(rd_idx), .rdata(rd_bias)
   );

   assign loaded       = (state == STREAM);
   assign load_ready   = (state == LOAD);
   assign load_fire    = load_valid && load_ready;
   assign weight_valid = loaded && !w_done;
   assign bias_valid   = loaded && !b_done;
   assign weight       = loaded ? rd_weight : '0;
   assign bias         = loaded ? rd_bias : '0;
   assign w_fire       = weight_valid && weight_ready;
   assign b_fire       = bias_valid && bias_ready;
   // a beat retires once each channel has fired, in this cycle or an earlier one
   assign beat_done    = loaded && (w_fire || w_done) && (b_fire || b_done);
   assign row_end      = beat_done && (rd_idx == LAST);
   assign go_load      = row_end && (pending || reload_req);

   always_comb begin
      next_state = state;
      next_state = (load_fire && wr_idx == LAST) ? STREAM : go_load ? LOAD : state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= LOAD;
         wr_idx   <= '0;
         rd_idx   <= '0;
         w_done   <= 1'b0;
         b_done   <= 1'b0;
         pending  <= 1'b0;
         row_done <= 1'b0;
      end else begin
         state    <= next_state;
         row_done <= row_end;
         if (load_fire) wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
         if (beat_done) rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
         w_done   <= !beat_done && (w_done || w_fire);
         b_done   <= !beat_done && (b_done || b_fire);
         pending  <= loaded && !go_load && (pending || reload_req);
      end
   end
endmodule

// File: tb/tb_affine_param_streamer.sv
// tb_affine_param_streamer: directed and randomized-backpressure checks of the parameter streamer
module tb_affine_param_streamer;
   localparam int IW = 32, BW = 8, N = 4, D = 4;

   logic clk = 1'b0, rst = 1'b0;
   logic [N-1:0][IW-1:0] load_weight = '0, weight;
   logic [N-1:0][BW-1:0] load_bias = '0, bias;
   logic load_valid = 1'b0, reload_req = 1'b0, weight_ready = 1'b0, bias_ready = 1'b0;
   logic load_ready, weight_valid, bias_valid, row_done, loaded;
   logic [N-1:0][IW-1:0] ew [D];
   logic [N-1:0][BW-1:0] eb [D];
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   affine_param_streamer #(.IN_WIDTH(IW), .BIAS_WIDTH(BW), .IN_SIZE(N), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .load_weight(load_weight), .load_bias(load_bias), .load_valid(load_valid), .load_ready(load_ready),
      .reload_req(reload_req),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
      .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready),
      .row_done(row_done), .loaded(loaded)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) tick;
      checks++;
      if ({load_ready, weight_valid, bias_valid, row_done, loaded} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/wv/bv/rd/ld=%b want 10000",
                  {load_ready, weight_valid, bias_valid, row_done, loaded});
      end
      checks++;
      if (weight !== '0 || bias !== '0) begin
         errors++;
         $display("FAIL reset_data: got w=%h b=%h want 0", weight, bias);
      end
      rst = 1'b1;
      tick;
   endtask

   task automatic load_row(input int mode);
      for (int k = 0; k < D; k++) begin
         for (int l = 0; l < N; l++) begin
            ew[k][l] = (mode == 0) ? IW'(k * 16 + l) :
                       (mode == 1) ? 32'hAAAA_0000 + IW'(k * 256 + l) : 32'h1234_0000 + IW'(k * 256 + l);
            eb[k][l] = (mode == 0) ? BW'(k + l) : (mode == 1) ? BW'(8'h50 + k * 4 + l) : BW'(8'hC0 + k * 4 + l);
         end
         load_weight = ew[k];
         load_bias   = eb[k];
         load_valid  = 1'b1;
         checks++;
         if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready beat %0d: got %b want 1", k, load_ready);
         end
         tick;
         if (k < D - 1) begin
            checks++;
            if ({loaded, weight_valid, bias_valid} !== 3'b000) begin
               errors++;
               $display("FAIL early_valid beat %0d: got ld/wv/bv=%b want 000", k, {loaded, weight_valid, bias_valid});
            end
         end
      end
      load_valid = 1'b0;
      checks++;
      if ({loaded, weight_valid, bias_valid, load_ready} !== 4'b1110) begin
         errors++;
         $display("FAIL load_done: got ld/wv/bv/rdy=%b want 1110", {loaded, weight_valid, bias_valid, load_ready});
      end
   endtask

   task automatic test_stream;
      weight_ready = 1'b1;
      bias_ready   = 1'b1;
      for (int i = 0; i < 2 * D; i++) begin
         checks++;
         if (weight_valid !== 1'b1 || bias_valid !== 1'b1 || weight !== ew[i % D] || bias !== eb[i % D]) begin
            errors++;
            $display("FAIL stream beat %0d: got v=%b%b w=%h b=%h want v=11 w=%h b=%h",
                     i, weight_valid, bias_valid, weight, bias, ew[i % D], eb[i % D]);
         end
         tick;
         checks++;
         if (row_done !== (i % D == D - 1)) begin
            errors++;
            $display("FAIL row_done after beat %0d: got %b want %b", i, row_done, (i % D == D - 1));
         end
      end
   endtask

   task automatic test_backpressure;
      weight_ready = 1'b1;
      bias_ready   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (weight_valid !== (i == 0) || bias_valid !== 1'b1 || weight !== ew[0] || bias !== eb[0]) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: got v=%b%b w=%h b=%h want wv=%b bv=1 w=%h b=%h",
                     i, weight_valid, bias_valid, weight, bias, (i == 0), ew[0], eb[0]);
         end
         tick;
      end
      bias_ready = 1'b1;
      checks++;
      if (weight_valid !== 1'b0 || bias_valid !== 1'b1 || bias !== eb[0]) begin
         errors++;
         $display("FAIL bp_bias_fire: got v=%b%b b=%h want v=01 b=%h", weight_valid, bias_valid, bias, eb[0]);
      end
      tick;
      checks++;
      if (weight_valid !== 1'b1 || bias_valid !== 1'b1 || weight !== ew[1] || bias !== eb[1]) begin
         errors++;
         $display("FAIL bp_next_beat: got v=%b%b w=%h b=%h want v=11 w=%h b=%h",
                  weight_valid, bias_valid, weight, bias, ew[1], eb[1]);
      end
      repeat (D - 1) tick;
   endtask

   task automatic test_random;
      int wi = 0, bi = 0, wf = 0, bf = 0;
      logic wh = 1'b0, bh = 1'b0;
      logic [N-1:0][IW-1:0] pw = '0;
      logic [N-1:0][BW-1:0] pb = '0;
      for (int c = 0; c < 1000; c++) begin
         weight_ready = 1'($urandom_range(0, 1));
         bias_ready   = 1'($urandom_range(0, 1));
         if (wh) begin
            checks++;
            if (weight_valid !== 1'b1 || weight !== pw) begin
               errors++;
               $display("FAIL rnd_w_stable cycle %0d: got wv=%b w=%h want 1 %h", c, weight_valid, weight, pw);
            end
         end
         if (bh) begin
            checks++;
            if (bias_valid !== 1'b1 || bias !== pb) begin
               errors++;
               $display("FAIL rnd_b_stable cycle %0d: got bv=%b b=%h want 1 %h", c, bias_valid, bias, pb);
            end
         end
         if (weight_valid === 1'b1) begin
            checks++;
            if (weight !== ew[wi]) begin
               errors++;
               $display("FAIL rnd_w_seq cycle %0d: got %h want %h", c, weight, ew[wi]);
            end
         end
         if (bias_valid === 1'b1) begin
            checks++;
            if (bias !== eb[bi]) begin
               errors++;
               $display("FAIL rnd_b_seq cycle %0d: got %h want %h", c, bias, eb[bi]);
            end
         end
         wh = weight_valid && !weight_ready;
         bh = bias_valid && !bias_ready;
         pw = weight;
         pb = bias;
         if (weight_valid && weight_ready) begin wi = (wi + 1) % D; wf++; end
         if (bias_valid && bias_ready) begin bi = (bi + 1) % D; bf++; end
         tick;
      end
      checks++;
      if (wf < 200 || bf < 200) begin
         errors++;
         $display("FAIL rnd_progress: got w_fires=%0d b_fires=%0d want >=200 each", wf, bf);
      end
      weight_ready = 1'b1;
      bias_ready   = 1'b1;
      for (int c = 0; c < 12 && !(wi == 0 && bi == 0); c++) begin
         if (weight_valid) wi = (wi + 1) % D;
         if (bias_valid) bi = (bi + 1) % D;
         tick;
      end
      checks++;
      if (wi != 0 || bi != 0 || weight_valid !== 1'b1 || bias_valid !== 1'b1 || weight !== ew[0]) begin
         errors++;
         $display("FAIL rnd_realign: got wi=%0d bi=%0d v=%b%b w=%h want 0 0 11 %h",
                  wi, bi, weight_valid, bias_valid, weight, ew[0]);
      end
   endtask

   task automatic test_reload;
      weight_ready = 1'b1;
      bias_ready   = 1'b1;
      tick;
      reload_req = 1'b1;
      checks++;
      if (weight_valid !== 1'b1 || weight !== ew[1]) begin
         errors++;
         $display("FAIL reload_beat1: got wv=%b w=%h want 1 %h", weight_valid, weight, ew[1]);
      end
      tick;
      reload_req = 1'b0;
      for (int k = 2; k < D; k++) begin
         checks++;
         if (weight_valid !== 1'b1 || bias_valid !== 1'b1 || weight !== ew[k] || bias !== eb[k]) begin
            errors++;
            $display("FAIL reload_tail beat %0d: got v=%b%b w=%h b=%h want 11 %h %h",
                     k, weight_valid, bias_valid, weight, bias, ew[k], eb[k]);
         end
         tick;
      end
      checks++;
      if ({row_done, load_ready, weight_valid, bias_valid, loaded} !== 5'b11000) begin
         errors++;
         $display("FAIL reload_enter_load: got rd/rdy/wv/bv/ld=%b want 11000",
                  {row_done, load_ready, weight_valid, bias_valid, loaded});
      end
      load_row(1);
      checks++;
      if (weight !== ew[0] || weight[2] !== 32'hAAAA_0002 || bias !== eb[0]) begin
         errors++;
         $display("FAIL reload_new_data: got w=%h b=%h want %h %h", weight, bias, ew[0], eb[0]);
      end
   endtask

   task automatic test_reload_at_end;
      weight_ready = 1'b1;
      bias_ready   = 1'b1;
      repeat (D - 1) tick;
      reload_req = 1'b1;
      checks++;
      if (weight_valid !== 1'b1 || weight !== ew[D - 1]) begin
         errors++;
         $display("FAIL end_reload_beat3: got wv=%b w=%h want 1 %h", weight_valid, weight, ew[D - 1]);
      end
      tick;
      checks++;
      if ({row_done, load_ready, weight_valid, bias_valid, loaded} !== 5'b11000) begin
         errors++;
         $display("FAIL end_reload_load: got rd/rdy/wv/bv/ld=%b want 11000",
                  {row_done, load_ready, weight_valid, bias_valid, loaded});
      end
      tick;
      reload_req = 1'b0;
      load_row(0);
      repeat (D) tick;
      checks++;
      if ({loaded, load_ready, weight_valid} !== 3'b101 || weight !== ew[0]) begin
         errors++;
         $display("FAIL load_reload_ignored: got ld/rdy/wv=%b w=%h want 101 %h",
                  {loaded, load_ready, weight_valid}, weight, ew[0]);
      end
   endtask

   task automatic test_async_reset;
      weight_ready = 1'b1;
      bias_ready   = 1'b1;
      repeat (2) tick;
      bias_ready = 1'b0;
      tick;
      checks++;
      if (weight_valid !== 1'b0 || bias_valid !== 1'b1 || bias !== eb[2]) begin
         errors++;
         $display("FAIL half_beat: got v=%b%b b=%h want 01 %h", weight_valid, bias_valid, bias, eb[2]);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({load_ready, weight_valid, bias_valid, row_done, loaded} !== 5'b10000 || weight !== '0 || bias !== '0) begin
         errors++;
         $display("FAIL async_reset: got rdy/wv/bv/rd/ld=%b w=%h b=%h want 10000 0 0",
                  {load_ready, weight_valid, bias_valid, row_done, loaded}, weight, bias);
      end
      tick;
      rst = 1'b1;
      bias_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({load_ready, weight_valid, bias_valid, loaded} !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d: got rdy/wv/bv/ld=%b want 1000",
                     i, {load_ready, weight_valid, bias_valid, loaded});
         end
         tick;
      end
      load_row(2);
      checks++;
      if (weight !== ew[0] || bias !== eb[0]) begin
         errors++;
         $display("FAIL post_reset_data: got w=%h b=%h want %h %h", weight, bias, ew[0], eb[0]);
      end
   endtask

   initial begin
      test_reset;
      load_row(0);
      test_stream;
      test_backpressure;
      test_random;
      test_reload;
      test_reload_at_end;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
